// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: default geometry and the fetched
// {pc, instr} record passed from fetch to decode.
package imem_pkg;
   localparam int ADDR_WIDTH  = 10;
   localparam int DATA_WIDTH  = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush clears it and wins over push.
module fetch_fifo
   import imem_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type ENTRY_T = fetch_entry_t,
   localparam int CW      = $clog2(DEPTH + 1),
   localparam int PW      = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  ENTRY_T        wdata,
   output ENTRY_T        head,
   output logic [CW-1:0] count
);
   ENTRY_T        mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, tracks the one-cycle ROM
// latency and streams (pc, instr) pairs to decode through a small FIFO.
module imem_fetch_ctrl #(
   parameter int                    ADDR_WIDTH = imem_pkg::ADDR_WIDTH,
   parameter int                    DATA_WIDTH = imem_pkg::DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = imem_pkg::RESET_PC,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_data_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(FIFO_DEPTH) + 2;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } entry_t;

   logic [ADDR_WIDTH-1:0] fetch_pc, inflight_pc;
   logic                  inflight;
   logic [CW-1:0]         count;
   logic [SW-1:0]         occupancy;
   logic                  pop, push, issue;
   entry_t                head, wdata;

   assign valid_o = (count != '0);
   assign pop     = valid_o & ready_i;
   assign push    = inflight & ~redirect_i;

   // The in-flight word already owns a FIFO slot, so it counts toward fullness.
   assign occupancy = SW'(count) + SW'(inflight) - SW'(pop);
   assign issue     = ~redirect_i & (occupancy < SW'(FIFO_DEPTH));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         fetch_pc    <= RESET_PC;
         inflight_pc <= RESET_PC;
         inflight    <= 1'b0;
      end else if (redirect_i) begin
         fetch_pc <= redirect_pc_i & ~ADDR_WIDTH'(imem_pkg::INSTR_BYTES - 1);
         inflight <= 1'b0;
      end else if (issue) begin
         inflight    <= 1'b1;
         inflight_pc <= fetch_pc;
         fetch_pc    <= fetch_pc + ADDR_WIDTH'(imem_pkg::INSTR_BYTES);
      end else begin
         inflight <= 1'b0;
      end
   end

   assign wdata = '{pc: inflight_pc, instr: imem_data_i};

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .ENTRY_T (entry_t)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (push),
      .pop    (pop),
      .flush  (redirect_i),
      .wdata  (wdata),
      .head   (head),
      .count  (count)
   );

   assign imem_addr_o = fetch_pc;
   assign instr_o     = head.instr;
   assign pc_o        = head.pc;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed timing checks plus a scoreboard that
// expects each restart to deliver a sequential, gap-free pc stream.
module tb_imem_fetch_ctrl;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam logic [AW-1:0] RPC = '0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          redirect = 1'b0;
   logic          ready = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic [AW-1:0] imem_addr, pc_o;
   logic [DW-1:0] imem_data, instr_o;
   logic          valid_o;

   always #5 clk = ~clk;

   imem_fetch_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RESET_PC   (RPC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .imem_addr_o   (imem_addr),
      .imem_data_i   (imem_data),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .valid_o       (valid_o),
      .ready_i       (ready),
      .instr_o       (instr_o),
      .pc_o          (pc_o)
   );

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return 32'h1000_0000 + DW'(a >> 2);
   endfunction

   // Synchronous ROM: data one cycle after the address.
   always @(posedge clk) imem_data <= rom_word(imem_addr);

   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   int            compared = 0;
   int            mismatched = 0;
   int            pops = 0;
   logic          mon_en = 1'b0;
   logic          restart = 1'b0;
   logic [AW-1:0] restart_pc = '0;
   logic [AW-1:0] next_pc = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n && valid_o === 1'b1 && ready) begin
         pops++;
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL stream: unexpected delivery pc %h, expected none", pc_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("stream_pc", 32'(pc_o), 32'(mon_e.pc));
            chk("stream_instr", instr_o, mon_e.instr);
         end
      end
   end

   // Drive one cycle of inputs; a redirect or reset in the previous cycle
   // restarts the expected stream at its target.
   task automatic step(input logic rdy, input logic redir, input logic [AW-1:0] rpc,
                       input logic rstn);
      @(posedge clk);
      #1;
      if (restart) begin
         exp_q.delete();
         next_pc = restart_pc;
         restart = 1'b0;
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back('{next_pc, rom_word(next_pc)});
         next_pc = next_pc + AW'(4);
      end
      ready       = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      rst_n       = rstn;
      if (!rstn) begin
         restart    = 1'b1;
         restart_pc = RPC;
      end else if (redir) begin
         restart    = 1'b1;
         restart_pc = rpc & ~AW'(3);
      end
   endtask

   task automatic run(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(rdy, 1'b0, '0, 1'b1);
   endtask

   task automatic chk_out(input string name, input logic v, input logic [AW-1:0] addr);
      chk({name, "_valid"}, 32'(valid_o), 32'(v));
      chk({name, "_addr"}, 32'(imem_addr), 32'(addr));
   endtask

   task automatic startup(input string tag);
      step(1'b1, 1'b0, '0, 1'b1);
      chk_out({tag, "_c0"}, 1'b0, RPC);
      step(1'b1, 1'b0, '0, 1'b1);
      chk_out({tag, "_c1"}, 1'b0, RPC + AW'(4));
      step(1'b1, 1'b0, '0, 1'b1);
      chk_out({tag, "_c2"}, 1'b1, RPC + AW'(8));
      chk({tag, "_c2_pc"}, 32'(pc_o), 32'(RPC));
   endtask

   initial begin
      step(1'b0, 1'b0, '0, 1'b0);
      mon_en = 1'b1;
      step(1'b0, 1'b0, '0, 1'b0);
      chk_out("reset", 1'b0, RPC);

      startup("boot");
      step(1'b1, 1'b0, '0, 1'b1);
      chk("c3_pc", 32'(pc_o), 32'h4);

      // Back-pressure: six stalled cycles starting with pc 8 at the head.
      step(1'b0, 1'b0, '0, 1'b1);
      chk("stall_c4_pc", 32'(pc_o), 32'h8);
      chk_out("stall_c4", 1'b1, AW'(16));
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
      chk_out("stall_c9", 1'b1, AW'(16));
      chk("stall_c9_pc", 32'(pc_o), 32'h8);

      // Redirect to an unaligned address near the top while full.
      step(1'b0, 1'b1, AW'(10'h3FE), 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      chk_out("redir_r1", 1'b0, AW'(10'h3FC));
      step(1'b1, 1'b0, '0, 1'b1);
      chk("redir_r2_valid", 32'(valid_o), 32'h0);
      step(1'b1, 1'b0, '0, 1'b1);
      chk("redir_r3_valid", 32'(valid_o), 32'h1);
      chk("redir_r3_pc", 32'(pc_o), 32'h3FC);
      step(1'b1, 1'b0, '0, 1'b1);
      chk("wrap_pc", 32'(pc_o), 32'h0);
      run(4, 1'b1);

      // Redirect concurrent with a pop and an in-flight word.
      step(1'b1, 1'b1, AW'(10'h100), 1'b1);
      chk("popredir_valid", 32'(valid_o), 32'h1);
      run(2, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      chk("popredir_r3_pc", 32'(pc_o), 32'h100);
      run(3, 1'b1);

      // Back-to-back redirects: only the second target is delivered.
      step(1'b1, 1'b1, AW'(10'h40), 1'b1);
      step(1'b1, 1'b1, AW'(10'h80), 1'b1);
      run(2, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      chk("b2b_valid", 32'(valid_o), 32'h1);
      chk("b2b_pc", 32'(pc_o), 32'h80);
      run(3, 1'b1);

      // Reset mid-stream with the FIFO full.
      run(4, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      chk("midrst_pre_valid", 32'(valid_o), 32'h1);
      startup("midrst");
      run(3, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         logic          rdy, rdr, rn;
         logic [AW-1:0] tgt;
         rdy = ($urandom_range(0, 3) != 0);
         rdr = ($urandom_range(0, 24) == 0);
         rn  = ($urandom_range(0, 199) != 0);
         tgt = AW'($urandom);
         step(rdy, rdr, tgt, rn);
      end
      run(12, 1'b1);
      chk("drain_valid", 32'(valid_o), 32'h1);
      chk("enough_pops", 32'(pops > 300), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
